// File: rtl/msg_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msg_decoder_pkg                                               |
// | Purpose  : Shared types and constants for the ASCII command decoder:     |
// |            parser state enum, protocol characters, digits per field.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package msg_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_TERM = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam logic [7:0] c_ascii_r  = 8'h52;  // 'R'
  localparam logic [7:0] c_ascii_w  = 8'h57;  // 'W'
  localparam logic [7:0] c_ascii_cr = 8'h0D;  // '\r'
  localparam logic [7:0] c_ascii_lf = 8'h0A;  // '\n'

  localparam int         c_digits_per_field = 4;
  localparam logic [1:0] c_last_digit       = 2'(c_digits_per_field - 1);

  function automatic logic is_term(input logic [7:0] b);
    return (b == c_ascii_cr) || (b == c_ascii_lf);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_decoder_hex_to_nibble.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hex_to_nibble                                                 |
// | Purpose  : Combinational ASCII hex digit decoder (0-9, A-F, a-f).        |
// | Ports    : byte_i   - received character                                 |
// |            nibble_o - 4-bit digit value (0 when not a hex digit)         |
// |            valid_o  - high when byte_i is a hex digit                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hex_to_nibble (
  input  logic [7:0] byte_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nibble_o = byte_i[3:0];
      valid_o  = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      nibble_o = byte_i[3:0] + 4'd9;
      valid_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msg_decoder                                                   |
// | Purpose  : Parses the ASCII read/write protocol from a valid-only byte   |
// |            stream and issues one bus request per well-formed message.    |
// |            "R" + 4 hex addr + CR/LF  -> read                             |
// |            "W" + 4 hex addr + 4 hex data + CR/LF -> write                |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            axiid, axiiv    - received byte and its one-cycle strobe      |
// |            req_addr/data   - parsed address / write data (0 for reads)   |
// |            req_rw          - 1 = write, 0 = read                         |
// |            req_valid/ready - request handshake                           |
// |            err_count       - saturating malformed-message counter        |
// |                              (only with MSG_DECODER_ERR_CNT_EN defined)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module msg_decoder
  import msg_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            axiid,
  input  logic                  axiiv,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_rw,
  output logic                  req_valid
`ifdef MSG_DECODER_ERR_CNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rw_q;
  logic                  valid_q;

  logic [3:0]            digit_nibble;
  logic                  digit_valid;

  hex_to_nibble u_hex (
    .byte_i   (axiid),
    .nibble_o (digit_nibble),
    .valid_o  (digit_valid)
  );

  // Address/data registers drive the outputs directly; they only change
  // while parsing, so they are frozen for the whole HOLD phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Anything other than a command letter (e.g. LF after CR) is noise
          if (axiiv && (axiid == c_ascii_r || axiid == c_ascii_w)) begin
            state_q <= ST_ADDR;
            rw_q    <= (axiid == c_ascii_w);
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= 2'd0;
          end
        end
        ST_ADDR: begin
          if (axiiv) begin
            if (digit_valid) begin
              addr_q <= {addr_q[ADDR_WIDTH-5:0], digit_nibble};
              cnt_q  <= cnt_q + 2'd1;
              if (cnt_q == c_last_digit) begin
                state_q <= rw_q ? ST_DATA : ST_TERM;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (axiiv) begin
            if (digit_valid) begin
              data_q <= {data_q[DATA_WIDTH-5:0], digit_nibble};
              cnt_q  <= cnt_q + 2'd1;
              if (cnt_q == c_last_digit) begin
                state_q <= ST_TERM;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_TERM: begin
          if (axiiv) begin
            if (is_term(axiid)) begin
              state_q <= ST_HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (req_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_addr  = addr_q;
  assign req_data  = data_q;
  assign req_rw    = rw_q;
  assign req_valid = valid_q;

`ifdef MSG_DECODER_ERR_CNT_EN
  logic       err_event;
  logic [7:0] err_cnt_q;

  // Any byte seen in HOLD is an error, including one arriving in the same
  // cycle the handshake completes.
  always_comb begin
    err_event = 1'b0;
    if (axiiv) begin
      case (state_q)
        ST_ADDR, ST_DATA: err_event = !digit_valid;
        ST_TERM:          err_event = !is_term(axiid);
        ST_HOLD:          err_event = 1'b1;
        default:          err_event = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_event && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_msg_decoder                                                |
// | Purpose  : Self-checking bench for msg_decoder: directed protocol cases  |
// |            with literal expectations plus randomized message traffic     |
// |            compared every cycle against a string-level parser model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_msg_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  axiid;
  logic        axiiv;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_rw;
  logic        req_valid;
`ifdef MSG_DECODER_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  msg_decoder #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .axiid     (axiid),
    .axiiv     (axiiv),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rw    (req_rw),
    .req_valid (req_valid)
`ifdef MSG_DECODER_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (message-string level) ----------------
  bit          m_live = 1'b0;
  bit          m_pend;
  bit          m_in;
  bit          m_rw;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  int          m_err;
  logic [7:0]  m_buf[$];

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  function automatic logic [7:0] hex_char(input int d, input bit lower);
    if (d < 10) return 8'(48 + d);
    return lower ? 8'(87 + d) : 8'(55 + d);
  endfunction

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  always @(posedge clk) begin
    bit          hold_was;
    int          need;
    int          v;
    logic [7:0]  b;
    if (rst) begin
      m_live = 1'b1;
      m_pend = 1'b0;
      m_in   = 1'b0;
      m_err  = 0;
      m_buf.delete();
    end else if (m_live) begin
      hold_was = m_pend;
      if (m_pend && req_ready) m_pend = 1'b0;
      if (axiiv) begin
        b = axiid;
        if (hold_was) begin
          model_err();
        end else if (!m_in) begin
          if (b == 8'h52 || b == 8'h57) begin
            m_in = 1'b1;
            m_buf.delete();
            m_buf.push_back(b);
          end
        end else begin
          need = (m_buf[0] == 8'h57) ? 9 : 5;
          if (m_buf.size() == need) begin
            m_in = 1'b0;
            if (b == 8'h0D || b == 8'h0A) begin
              m_pend = 1'b1;
              m_rw   = (m_buf[0] == 8'h57);
              v = 0;
              for (int i = 1; i <= 4; i++) v = v * 16 + hexval(m_buf[i]);
              m_addr = 16'(v);
              v = 0;
              if (m_rw) for (int i = 5; i <= 8; i++) v = v * 16 + hexval(m_buf[i]);
              m_data = 16'(v);
            end else begin
              model_err();
            end
          end else if (is_hex(b)) begin
            m_buf.push_back(b);
          end else begin
            m_in = 1'b0;
            model_err();
          end
        end
      end
    end
  end

  // Single compare point, half a cycle after every active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("valid", {31'd0, req_valid}, {31'd0, m_pend});
      if (m_pend) begin
        check("addr", {16'd0, req_addr}, {16'd0, m_addr});
        check("data", {16'd0, req_data}, {16'd0, m_data});
        check("rw",   {31'd0, req_rw},   {31'd0, m_rw});
      end
`ifdef MSG_DECODER_ERR_CNT_EN
      check("err_count", {24'd0, err_count}, 32'(m_err));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) req_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    axiid = b;
    axiiv = 1'b1;
    @(negedge clk);
    axiiv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic err_is(input string name, input int exp);
`ifdef MSG_DECODER_ERR_CNT_EN
    check(name, {24'd0, err_count}, 32'(exp));
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg[$];
    int         kind;
    rst = 1'b1; axiiv = 1'b0; axiid = 8'h00; req_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, req_valid}, 32'd0);
    check("rst_addr",  {16'd0, req_addr},  32'd0);
    check("rst_data",  {16'd0, req_data},  32'd0);
    check("rst_rw",    {31'd0, req_rw},    32'd0);
    err_is("rst_err", 0);
    rst = 1'b0;

    // Read with ready high: one-cycle request
    req_ready = 1'b1;
    send_str("R0003"); send_byte(8'h0D, 0);
    check("A_valid", {31'd0, req_valid}, 32'd1);
    check("A_addr",  {16'd0, req_addr},  32'h0003);
    check("A_data",  {16'd0, req_data},  32'h0000);
    check("A_rw",    {31'd0, req_rw},    32'd0);
    @(negedge clk);
    check("A_drop",  {31'd0, req_valid}, 32'd0);

    // Write with mixed-case digits and trailing LF
    send_str("W0012aBcD"); send_byte(8'h0D, 0);
    check("B_addr", {16'd0, req_addr}, 32'h0012);
    check("B_data", {16'd0, req_data}, 32'hABCD);
    check("B_rw",   {31'd0, req_rw},   32'd1);
    send_byte(8'h0A, 2);
    err_is("B_err", 0);

    // Non-hex digit, then a good read
    send_str("R12G4"); send_byte(8'h0D, 0);
    send_str("R0001"); send_byte(8'h0A, 0);
    check("E_valid", {31'd0, req_valid}, 32'd1);
    check("E_addr",  {16'd0, req_addr},  32'h0001);
    check("E_rw",    {31'd0, req_rw},    32'd0);
    err_is("E_err", 1);

    // Early terminator and bad terminator
    do_reset();
    send_str("R001"); send_byte(8'h0D, 0);
    send_str("W00011234X");
    repeat (3) @(negedge clk);
    check("F_valid", {31'd0, req_valid}, 32'd0);
    err_is("F_err", 2);

    // Back-pressure with a byte dropped during hold
    do_reset();
    req_ready = 1'b0;
    send_str("R00FF"); send_byte(8'h0D, 0);
    check("C_valid0", {31'd0, req_valid}, 32'd1);
    send_byte(8'h57, 2);
    check("C_valid1", {31'd0, req_valid}, 32'd1);
    check("C_addr",   {16'd0, req_addr},  32'h00FF);
    check("C_rw",     {31'd0, req_rw},    32'd0);
    err_is("C_err", 1);
    req_ready = 1'b1;
    @(negedge clk);
    check("C_done", {31'd0, req_valid}, 32'd0);

    // Reset mid-message
    send_str("W12");
    do_reset();
    check("D_valid0", {31'd0, req_valid}, 32'd0);
    send_str("R0002"); send_byte(8'h0D, 0);
    check("D_valid1", {31'd0, req_valid}, 32'd1);
    check("D_addr",   {16'd0, req_addr},  32'h0002);
    check("D_data",   {16'd0, req_data},  32'h0000);
    check("D_rw",     {31'd0, req_rw},    32'd0);

    // Error counter saturation while holding
    do_reset();
    req_ready = 1'b0;
    send_str("R0000"); send_byte(8'h0D, 0);
    for (int i = 0; i < 260; i++) send_byte(8'h41, 0);
    check("S_valid", {31'd0, req_valid}, 32'd1);
    err_is("S_err", 255);
    req_ready = 1'b1;
    @(negedge clk);

    // Randomized traffic
    do_reset();
    rand_ready = 1'b1;
    for (int m = 0; m < 200; m++) begin
      kind = $urandom_range(0, 9);
      msg.delete();
      if (kind == 9) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) msg.push_back(8'($urandom_range(0, 255)));
      end else begin
        msg.push_back($urandom_range(0, 1) ? 8'h57 : 8'h52);
        for (int j = 0; j < ((msg[0] == 8'h57) ? 8 : 4); j++)
          msg.push_back(hex_char(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
        msg.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        if ($urandom_range(0, 2) == 0) msg.push_back(8'h0A);
        if (kind == 8) msg[$urandom_range(msg.size() - 1, 1)] = 8'($urandom_range(0, 255));
      end
      foreach (msg[j]) begin
        send_byte(msg[j], int'($urandom_range(0, 2)));
        if ($urandom_range(0, 149) == 0) do_reset();
      end
    end
    rand_ready = 1'b0;
    req_ready  = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
